bridge_rx: RTL and testbench

Receive-side bus bridge at the head of the core chain: consumes host bytes (already deserialized by the UART receiver) and turns ASCII-hex request lines into single-cycle transactions on the 16-bit daisy-chain bus. This bus is the one every memory-mapped core (BRAM, logic analyzer, IO) passes through. The block drives the chain's first `addr/wdata/rdata/rw/valid` inputs. It has no backpressure: every core accepts one transaction per cycle, so the bridge only issues and never waits.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/hex_decode.sv | 23 ++
 rtl/bridge_rx.sv | 128 ++++++++++++
 tb/tb_bridge_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the host-side bridge: bus width, ASCII tokens,
// receive FSM states and per-command digit counts.
package bridge_pkg;

   localparam int BUS_WIDTH = 16;

   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_W  = 8'h57;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam logic [3:0] RD_DIGITS = 4'd4;
   localparam logic [3:0] WR_DIGITS = 4'd8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } rx_state_t;

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

endpackage

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder: byte in, nibble plus is_hex flag out.
// Accepts 0-9, A-F and a-f; any other byte yields is_hex_o = 0 and nibble 0.
module hex_decode (
   input  logic [7:0] data_i,
   output logic [3:0] nib_o,
   output logic       is_hex_o
);

   always_comb begin
      nib_o    = 4'h0;
      is_hex_o = 1'b0;
      if (data_i >= 8'h30 && data_i <= 8'h39) begin
         nib_o    = data_i[3:0];
         is_hex_o = 1'b1;
      end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                   (data_i >= 8'h61 && data_i <= 8'h66)) begin
         // Low nibble of 'A'/'a' is 1, so +9 maps it to 10.
         nib_o    = data_i[3:0] + 4'd9;
         is_hex_o = 1'b1;
      end
   end

endmodule

// File: rtl/bridge_rx.sv
// Receive bridge: parses ASCII-hex "Raaaa" / "Waaaadddd" lines into one-cycle
// bus strobes. Optional dropped-message counter with BRIDGE_RX_ERR_CNT_EN.
module bridge_rx
   import bridge_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           data_i,
   input  logic                 valid_i,
   output logic [BUS_WIDTH-1:0] addr_o,
   output logic [BUS_WIDTH-1:0] wdata_o,
   output logic [BUS_WIDTH-1:0] rdata_o,
   output logic                 rw_o,
   output logic                 valid_o
`ifdef BRIDGE_RX_ERR_CNT_EN
   ,
   output logic [BUS_WIDTH-1:0] err_cnt_o
`endif
);

   localparam int SH_W = 2 * BUS_WIDTH;

   rx_state_t         state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [SH_W-1:0]   shift_q, shift_d;
   logic              rw_q, rw_d;
   logic [BUS_WIDTH-1:0] addr_q, wdata_q;
   logic              rw_out_q, valid_q;
   logic              issue, err;
   logic [3:0]        limit;
   logic [3:0]        nib;
   logic              is_hex;

   hex_decode u_hex (
      .data_i   (data_i),
      .nib_o    (nib),
      .is_hex_o (is_hex)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      rw_d    = rw_q;
      issue   = 1'b0;
      err     = 1'b0;
      limit   = (state_q == WRITE) ? WR_DIGITS : RD_DIGITS;
      if (valid_i) begin
         unique case (state_q)
            IDLE: begin
               if (data_i == ASCII_R) begin
                  state_d = READ;
                  cnt_d   = 4'd0;
                  rw_d    = 1'b0;
               end else if (data_i == ASCII_W) begin
                  state_d = WRITE;
                  cnt_d   = 4'd0;
                  rw_d    = 1'b1;
               end else if (!is_term(data_i)) begin
                  err = 1'b1;
               end
            end
            READ, WRITE: begin
               if (is_hex && cnt_q < limit) begin
                  shift_d = {shift_q[SH_W-5:0], nib};
                  cnt_d   = cnt_q + 4'd1;
               end else if (is_term(data_i) && cnt_q == limit) begin
                  issue = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            default: err = 1'b1;
         endcase
      end
      // Both a completed message and a dropped one resume parsing from IDLE.
      if (issue || err) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         shift_q  <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rw_out_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         rw_q    <= rw_d;
         valid_q <= issue;
         if (issue) begin
            rw_out_q <= rw_q;
            if (rw_q) begin
               addr_q  <= shift_q[SH_W-1:BUS_WIDTH];
               wdata_q <= shift_q[BUS_WIDTH-1:0];
            end else begin
               addr_q  <= shift_q[BUS_WIDTH-1:0];
            end
         end
      end
   end

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign rdata_o = '0;
   assign rw_o    = rw_out_q;
   assign valid_o = valid_q;

`ifdef BRIDGE_RX_ERR_CNT_EN
   logic [BUS_WIDTH-1:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (err && err_cnt_q != {BUS_WIDTH{1'b1}}) begin
         err_cnt_q <= err_cnt_q + BUS_WIDTH'(1);
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: a line-buffer model checked every cycle,
// plus directed literal checks. Exercises the counter when BRIDGE_RX_ERR_CNT_EN is set.
module tb_bridge_rx;

   logic        clk;
   logic        rst;
   logic [7:0]  data_i;
   logic        valid_i;
   logic [15:0] addr_o, wdata_o, rdata_o;
   logic        rw_o, valid_o;
`ifdef BRIDGE_RX_ERR_CNT_EN
   logic [15:0] err_cnt_o;
`endif

   bridge_rx dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .addr_o  (addr_o),
      .wdata_o (wdata_o),
      .rdata_o (rdata_o),
      .rw_o    (rw_o),
      .valid_o (valid_o)
`ifdef BRIDGE_RX_ERR_CNT_EN
      ,
      .err_cnt_o (err_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model: buffers the current line ----------------
   logic [7:0]  msg_q[$];
   logic [15:0] m_addr, m_wdata, m_err;
   logic        m_rw, m_valid;

   function automatic bit hexchar(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   function automatic logic [3:0] hexval(input logic [7:0] b);
      logic [7:0] v;
      if (b <= 8'h39)      v = b - 8'h30;
      else if (b <= 8'h46) v = b - 8'h37;
      else                 v = b - 8'h57;
      return v[3:0];
   endfunction

   task automatic model_step(input logic [7:0] b);
      bit          term, fire, bad;
      int          need, nd;
      logic [31:0] acc;
      term = (b == 8'h0D) || (b == 8'h0A);
      fire = 1'b0;
      bad  = 1'b0;
      if (msg_q.size() == 0) begin
         if (b == 8'h52 || b == 8'h57) msg_q.push_back(b);
         else if (!term) bad = 1'b1;
      end else begin
         need = (msg_q[0] == 8'h52) ? 4 : 8;
         nd   = msg_q.size() - 1;
         if (term && nd == need) begin
            acc = 0;
            for (int i = 1; i < msg_q.size(); i++) acc = acc * 16 + 32'(hexval(msg_q[i]));
            fire = 1'b1;
            if (need == 4) begin
               m_addr <= acc[15:0];
               m_rw   <= 1'b0;
            end else begin
               m_addr  <= acc[31:16];
               m_wdata <= acc[15:0];
               m_rw    <= 1'b1;
            end
            msg_q.delete();
         end else if (hexchar(b) && nd < need) begin
            msg_q.push_back(b);
         end else begin
            bad = 1'b1;
            msg_q.delete();
         end
      end
      m_valid <= fire;
      if (bad && m_err != 16'hFFFF) m_err <= m_err + 16'd1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_q.delete();
         m_addr  <= '0;
         m_wdata <= '0;
         m_rw    <= 1'b0;
         m_valid <= 1'b0;
         m_err   <= '0;
      end else if (valid_i) begin
         model_step(data_i);
      end else begin
         m_valid <= 1'b0;
      end
   end

   // ---------------- per-cycle compare and strobe capture ----------------
   logic [15:0] pa[$], pw[$];
   logic        pr[$];
   int          pc[$];

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_valid", {31'd0, valid_o}, {31'd0, m_valid});
         check("cmp_addr",  {16'd0, addr_o},  {16'd0, m_addr});
         check("cmp_wdata", {16'd0, wdata_o}, {16'd0, m_wdata});
         check("cmp_rw",    {31'd0, rw_o},    {31'd0, m_rw});
         check("cmp_rdata", {16'd0, rdata_o}, 32'd0);
`ifdef BRIDGE_RX_ERR_CNT_EN
         check("cmp_err",   {16'd0, err_cnt_o}, {16'd0, m_err});
`endif
         if (valid_o) begin
            pa.push_back(addr_o);
            pw.push_back(wdata_o);
            pr.push_back(rw_o);
            pc.push_back(cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      data_i  = b;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i  = 1'b0;
      last_cyc = cyc;
   endtask

   // Sends body then a CR; maxgap > 0 inserts random idle cycles after every byte.
   task automatic send_msg(input string s, input int maxgap);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         if (maxgap > 0) idle($urandom_range(maxgap, 0));
      end
      send(8'h0D);
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
   endtask

   initial begin
      int n0, cr_cyc;
      rst     = 1'b1;
      valid_i = 1'b0;
      data_i  = 8'h00;
      idle(3);
      rst = 1'b0;
      idle(1);

      check("rst_addr",  {16'd0, addr_o},  32'd0);
      check("rst_wdata", {16'd0, wdata_o}, 32'd0);
      check("rst_rw",    {31'd0, rw_o},    32'd0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
`ifdef BRIDGE_RX_ERR_CNT_EN
      check("rst_err",   {16'd0, err_cnt_o}, 32'd0);
`endif

      // Read with CRLF: the LF is ignored.
      n0 = pa.size();
      send_msg("R1234", 0);
      cr_cyc = last_cyc;
      send(8'h0A);
      idle(3);
      check("r1234_pulses", pa.size() - n0, 1);
      check("r1234_addr", {16'd0, pa[n0]}, 32'h1234);
      check("r1234_rw",   {31'd0, pr[n0]}, 32'd0);
      check("r1234_lat",  pc[n0], cr_cyc);

      // Write with lowercase data, LF terminator.
      n0 = pa.size();
      for (int i = 0; i < 9; i++) begin
         string s;
         s = "W00ABbeef";
         send(s[i]);
      end
      send(8'h0A);
      idle(3);
      check("w00ab_pulses", pa.size() - n0, 1);
      check("w00ab_addr",  {16'd0, pa[n0]}, 32'h00AB);
      check("w00ab_wdata", {16'd0, pw[n0]}, 32'hBEEF);
      check("w00ab_rw",    {31'd0, pr[n0]}, 32'd1);
      check("w00ab_rdata", {16'd0, rdata_o}, 32'd0);

      // Malformed lines: early terminator, fifth digit, non-hex digit.
      n0 = pa.size();
      send_msg("R12", 0);
      send_msg("R12345", 0);
`ifdef BRIDGE_RX_ERR_CNT_EN
      idle(1);
      check("bad2_err", {16'd0, err_cnt_o}, 32'd2);
`endif
      send_msg("W12G45678", 0);
      idle(2);
      check("bad_pulses", pa.size() - n0, 0);
`ifdef BRIDGE_RX_ERR_CNT_EN
      // After the 'G' the trailing 4,5,6,7,8 are seen from IDLE, one error each.
      check("bad3_err", {16'd0, err_cnt_o}, 32'd8);
`endif
      n0 = pa.size();
      send_msg("R0001", 0);
      idle(2);
      check("recover_pulses", pa.size() - n0, 1);
      check("recover_addr",  {16'd0, pa[n0]}, 32'h0001);
      check("recover_wdata", {16'd0, pw[n0]}, 32'hBEEF);

      // Back-to-back read then write, no idle cycles.
      n0 = pa.size();
      send_msg("R0001", 0);
      send_msg("W0002FFFF", 0);
      idle(3);
      check("b2b_pulses", pa.size() - n0, 2);
      check("b2b_addr0",  {16'd0, pa[n0]},   32'h0001);
      check("b2b_rw0",    {31'd0, pr[n0]},   32'd0);
      check("b2b_addr1",  {16'd0, pa[n0+1]}, 32'h0002);
      check("b2b_wdata1", {16'd0, pw[n0+1]}, 32'hFFFF);
      check("b2b_rw1",    {31'd0, pr[n0+1]}, 32'd1);
      // Ten bytes separate the two terminators.
      check("b2b_spacing", pc[n0+1] - pc[n0], 10);

      // Same pair again with random gaps; a write first so the read's wdata hold is visible.
      send_msg("W55AA1357", 0);
      idle(2);
      n0 = pa.size();
      send_msg("R0001", 4);
      send_msg("W0002FFFF", 4);
      idle(3);
      check("gap_pulses", pa.size() - n0, 2);
      check("gap_addr0",  {16'd0, pa[n0]},   32'h0001);
      check("gap_wdata0", {16'd0, pw[n0]},   32'h1357);
      check("gap_addr1",  {16'd0, pa[n0+1]}, 32'h0002);
      check("gap_wdata1", {16'd0, pw[n0+1]}, 32'hFFFF);

      // Reset in the middle of a write message.
      n0 = pa.size();
      for (int i = 0; i < 5; i++) begin
         string s;
         s = "W1234";
         send(s[i]);
      end
      #2 rst = 1'b1;
      #1;
      check("mrst_addr",  {16'd0, addr_o},  32'd0);
      check("mrst_wdata", {16'd0, wdata_o}, 32'd0);
      check("mrst_rw",    {31'd0, rw_o},    32'd0);
      check("mrst_valid", {31'd0, valid_o}, 32'd0);
`ifdef BRIDGE_RX_ERR_CNT_EN
      check("mrst_err",   {16'd0, err_cnt_o}, 32'd0);
`endif
      idle(2);
      rst = 1'b0;
      idle(2);
      check("mrst_pulses", pa.size() - n0, 0);
      send_msg("R00FF", 0);
      idle(2);
      check("post_rst_pulses", pa.size() - n0, 1);
      check("post_rst_addr", {16'd0, pa[n0]}, 32'h00FF);
      check("post_rst_wdata", {16'd0, pw[n0]}, 32'h0000);

`ifdef BRIDGE_RX_ERR_CNT_EN
      // Saturation: every 'X' from IDLE is an error.
      data_i  = 8'h58;
      valid_i = 1'b1;
      idle(65540);
      valid_i = 1'b0;
      idle(2);
      check("sat_err", {16'd0, err_cnt_o}, 32'hFFFF);
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
